// File: rtl/saber_render_unit.sv
// Saber renderer: takes a frame-synchronous snapshot of the saber register words,
// animates blade length and flicker once per frame, and runs a 2-stage per-pixel hit test.
module saber_render_unit #(
  parameter int          HALF_W         = 2,
  parameter int          HILT_LEN       = 16,
  parameter int          GROW_STEP      = 8,
  parameter int          FLICKER_FRAMES = 4,
  parameter logic [23:0] HILT_RGB       = 24'h808080,
  parameter int          MAX_LEN        = 400
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          FRAME_START,
  input  logic [2047:0] REG_DATA,
  input  logic          PIX_IN_VALID,
  input  logic [9:0]    DRAW_X,
  input  logic [9:0]    DRAW_Y,
  output logic          PIX_VALID,
  output logic          BLADE_HIT,
  output logic          HILT_HIT,
  output logic [7:0]    RED,
  output logic [7:0]    GREEN,
  output logic [7:0]    BLUE,
  output logic [9:0]    BLADE_LEN
);

  localparam int                 CNT_W     = $clog2(2 * FLICKER_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(2 * FLICKER_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_SHOWN = CNT_W'(FLICKER_FRAMES);
  localparam logic [9:0]         MAX_LEN_V = 10'(MAX_LEN);
  localparam logic [10:0]        STEP_V    = 11'(GROW_STEP);
  localparam logic signed [11:0] HW        = 12'(HALF_W);
  localparam logic signed [11:0] HILT_SPAN = 12'(HILT_LEN - 1);

  localparam logic [1:0] ST_ON      = 2'd1;
  localparam logic [1:0] ST_FLICKER = 2'd2;

  // Register conduit fields
  logic [9:0]  reg_x, reg_y, reg_len;
  logic [1:0]  reg_state;
  logic [23:0] reg_rgb;
  logic        unused_reg_bits;

  assign reg_x     = REG_DATA[9:0];
  assign reg_y     = REG_DATA[41:32];
  assign reg_state = REG_DATA[65:64];
  assign reg_len   = REG_DATA[105:96];
  assign reg_rgb   = REG_DATA[151:128];
  assign unused_reg_bits = ^{REG_DATA[2047:152], REG_DATA[127:106], REG_DATA[95:66],
                             REG_DATA[63:42], REG_DATA[31:10]};

  // Shadow registers and animation state
  logic [9:0]       sh_x, sh_y, sh_len, cur_len;
  logic [1:0]       sh_state;
  logic [23:0]      sh_rgb;
  logic             anim_pend;
  logic [CNT_W-1:0] flick_cnt;
  logic             flick_on;

  logic             blade_state;
  logic [10:0]      grow, shrink;
  logic [9:0]       next_len;

  assign blade_state = (sh_state == ST_ON) || (sh_state == ST_FLICKER);

  // NOTE: every variable assigned here gets a default first so no latch can be inferred.
  always_comb begin
    grow     = {1'b0, cur_len} + STEP_V;
    shrink   = {1'b0, cur_len} - STEP_V;
    next_len = cur_len;
    if (blade_state) begin
      if (cur_len < sh_len) next_len = (grow > {1'b0, sh_len}) ? sh_len : grow[9:0];
      else                  next_len = sh_len;
    end else begin
      next_len = shrink[10] ? '0 : shrink[9:0];
    end
  end

  // NOTE: synchronous active-high reset; all state uses non-blocking assignments.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sh_x      <= '0;
      sh_y      <= '0;
      sh_len    <= '0;
      sh_state  <= '0;
      sh_rgb    <= '0;
      anim_pend <= 1'b0;
      cur_len   <= '0;
      flick_cnt <= '0;
      flick_on  <= 1'b0;
    end else begin
      anim_pend <= FRAME_START;
      if (FRAME_START) begin
        sh_x     <= reg_x;
        sh_y     <= reg_y;
        sh_state <= reg_state;
        sh_len   <= (reg_len > MAX_LEN_V) ? MAX_LEN_V : reg_len;
        sh_rgb   <= reg_rgb;
      end
      if (anim_pend) begin
        cur_len <= next_len;
        // Visibility for the new frame is decided by the flicker frames already shown.
        if (sh_state == ST_FLICKER) begin
          flick_on  <= (flick_cnt < CNT_SHOWN);
          flick_cnt <= (flick_cnt == CNT_LAST) ? '0 : flick_cnt + 1'b1;
        end else begin
          flick_on  <= 1'b1;
          flick_cnt <= '0;
        end
      end
    end
  end

  assign BLADE_LEN = cur_len;

  // Stage 1 geometry in 12-bit signed so that X-HALF_W and Y-cur_len never wrap
  logic signed [11:0] px, py, sx, sy, x_lo, x_hi, yb_lo, yb_hi, yh_hi;
  logic               in_x, blade_geo, hilt_geo, blade_vis;

  always_comb begin
    px    = $signed({2'b00, DRAW_X});
    py    = $signed({2'b00, DRAW_Y});
    sx    = $signed({2'b00, sh_x});
    sy    = $signed({2'b00, sh_y});
    x_lo  = sx - HW;
    x_hi  = sx + HW;
    yb_lo = sy - $signed({2'b00, cur_len});
    yb_hi = sy - 12'sd1;
    yh_hi = sy + HILT_SPAN;
    if (x_lo[11])  x_lo  = '0;
    if (yb_lo[11]) yb_lo = '0;
    in_x      = (px >= x_lo) && (px <= x_hi);
    blade_geo = in_x && (py >= yb_lo) && (py <= yb_hi);
    hilt_geo  = in_x && (py >= sy) && (py <= yh_hi);
    blade_vis = (cur_len != '0) && flick_on;
  end

  logic        s1_valid, s1_blade, s1_hilt;
  logic [23:0] s1_rgb;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_valid  <= 1'b0;
      s1_blade  <= 1'b0;
      s1_hilt   <= 1'b0;
      s1_rgb    <= '0;
      PIX_VALID <= 1'b0;
      BLADE_HIT <= 1'b0;
      HILT_HIT  <= 1'b0;
      RED       <= '0;
      GREEN     <= '0;
      BLUE      <= '0;
    end else begin
      s1_valid  <= PIX_IN_VALID;
      s1_blade  <= PIX_IN_VALID && blade_geo && blade_vis;
      s1_hilt   <= PIX_IN_VALID && hilt_geo;
      s1_rgb    <= sh_rgb;
      PIX_VALID <= s1_valid;
      BLADE_HIT <= s1_blade;
      HILT_HIT  <= s1_hilt;
      if (s1_blade)     {RED, GREEN, BLUE} <= s1_rgb;
      else if (s1_hilt) {RED, GREEN, BLUE} <= HILT_RGB;
      else              {RED, GREEN, BLUE} <= '0;
    end
  end

endmodule

// File: tb/tb_saber_render_unit.sv
// Self-checking bench for saber_render_unit: directed tables, hand-written timing
// sequences and randomized frames compared against a behavioural model.
module tb_saber_render_unit;

  localparam int          HALF_W         = 2;
  localparam int          HILT_LEN       = 16;
  localparam int          GROW_STEP      = 8;
  localparam int          FLICKER_FRAMES = 4;
  localparam logic [23:0] HILT_RGB       = 24'h808080;
  localparam int          MAX_LEN        = 400;

  logic          CLK, RESET, FRAME_START, PIX_IN_VALID;
  logic [2047:0] reg_data;
  logic [9:0]    DRAW_X, DRAW_Y;
  logic          PIX_VALID, BLADE_HIT, HILT_HIT;
  logic [7:0]    RED, GREEN, BLUE;
  logic [9:0]    BLADE_LEN;

  saber_render_unit #(
    .HALF_W(HALF_W), .HILT_LEN(HILT_LEN), .GROW_STEP(GROW_STEP),
    .FLICKER_FRAMES(FLICKER_FRAMES), .HILT_RGB(HILT_RGB), .MAX_LEN(MAX_LEN)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FRAME_START(FRAME_START), .REG_DATA(reg_data),
    .PIX_IN_VALID(PIX_IN_VALID), .DRAW_X(DRAW_X), .DRAW_Y(DRAW_Y),
    .PIX_VALID(PIX_VALID), .BLADE_HIT(BLADE_HIT), .HILT_HIT(HILT_HIT),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .BLADE_LEN(BLADE_LEN)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Expected pixel results: {valid, blade, hilt, rgb}
  typedef struct { int due; logic [26:0] exp; } pend_t;
  pend_t exp_q[$];

  always @(negedge CLK) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("pixel", {5'b0, PIX_VALID, BLADE_HIT, HILT_HIT, RED, GREEN, BLUE},
            {5'b0, exp_q[0].exp});
      void'(exp_q.pop_front());
    end
  end

  // Behavioural model of the frame-level state
  int          m_x, m_y, m_state, m_tgt, m_len, m_fl;
  bit          m_vis;
  logic [23:0] m_rgb;

  function automatic void model_reset();
    m_x = 0; m_y = 0; m_state = 0; m_tgt = 0; m_len = 0; m_fl = 0; m_vis = 0; m_rgb = '0;
  endfunction

  function automatic void model_frame();
    m_x     = int'(reg_data[9:0]);
    m_y     = int'(reg_data[41:32]);
    m_state = int'(reg_data[65:64]);
    m_tgt   = int'(reg_data[105:96]);
    if (m_tgt > MAX_LEN) m_tgt = MAX_LEN;
    m_rgb   = reg_data[151:128];
    if (m_state == 1 || m_state == 2) begin
      if (m_len < m_tgt) m_len = (m_len + GROW_STEP < m_tgt) ? m_len + GROW_STEP : m_tgt;
      else               m_len = m_tgt;
    end else begin
      m_len = (m_len > GROW_STEP) ? m_len - GROW_STEP : 0;
    end
    if (m_state == 2) begin
      m_vis = (m_fl % (2 * FLICKER_FRAMES)) < FLICKER_FRAMES;
      m_fl++;
    end else begin
      m_vis = 1;
      m_fl  = 0;
    end
  endfunction

  function automatic logic [26:0] model_pix(input int x, input int y);
    bit inx, bl, hi;
    logic [23:0] c;
    inx = (x >= m_x - HALF_W) && (x <= m_x + HALF_W);
    bl  = m_vis && (m_len > 0) && inx && (y >= m_y - m_len) && (y < m_y);
    hi  = inx && (y >= m_y) && (y < m_y + HILT_LEN);
    c   = bl ? m_rgb : (hi ? HILT_RGB : 24'h0);
    return {1'b1, bl, hi, c};
  endfunction

  task automatic set_regs(input int x, input int y, input int st, input int len,
                          input logic [23:0] rgb);
    reg_data[31:0]    = $urandom; reg_data[9:0]     = 10'(x);
    reg_data[63:32]   = $urandom; reg_data[41:32]   = 10'(y);
    reg_data[95:64]   = $urandom; reg_data[65:64]   = 2'(st);
    reg_data[127:96]  = $urandom; reg_data[105:96]  = 10'(len);
    reg_data[159:128] = $urandom; reg_data[151:128] = rgb;
  endtask

  task automatic send_pix(input int x, input int y, input logic [26:0] e);
    @(posedge CLK); #1;
    PIX_IN_VALID = 1'b1;
    DRAW_X = 10'(x);
    DRAW_Y = 10'(y);
    exp_q.push_back('{due: cyc + 2, exp: e});
  endtask

  task automatic send_model(input int x, input int y);
    send_pix(x, y, model_pix(x, y));
  endtask

  task automatic send_idle();
    @(posedge CLK); #1;
    PIX_IN_VALID = 1'b0;
    DRAW_X = 10'($urandom);
    DRAW_Y = 10'($urandom);
    exp_q.push_back('{due: cyc + 2, exp: 27'h0});
  endtask

  task automatic drain();
    send_idle();
    for (int i = 0; i < 8; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK);
    end
    if (exp_q.size() != 0) begin
      check("drain timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic frame();
    @(posedge CLK); #1;
    FRAME_START  = 1'b1;
    PIX_IN_VALID = 1'b0;
    @(posedge CLK); #1;
    FRAME_START = 1'b0;
    @(posedge CLK); #1;
    model_frame();
  endtask

  typedef struct { int x; int y; logic [26:0] exp; } vec_t;
  localparam logic [26:0] NONE  = {3'b100, 24'h0};
  localparam logic [26:0] GREEN_BLADE = {3'b110, 24'h00FF00};
  localparam logic [26:0] HILT  = {3'b101, HILT_RGB};
  localparam logic [26:0] CLAMP_BLADE = {3'b110, 24'h3366CC};

  vec_t ext_tab[8];
  vec_t clamp_tab[7];
  int   ext_len[3];
  int   ret_len[2];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    ext_len = '{8, 16, 20};
    ret_len = '{4, 0};
    ext_tab = '{'{101, 280, GREEN_BLADE}, '{101, 279, NONE}, '{103, 290, NONE},
                '{98, 315, HILT}, '{98, 316, NONE}, '{102, 299, GREEN_BLADE},
                '{98, 300, HILT}, '{97, 300, NONE}};
    clamp_tab = '{'{0, 0, CLAMP_BLADE}, '{3, 0, CLAMP_BLADE}, '{4, 0, NONE},
                  '{0, 1023, NONE}, '{0, 1000, NONE}, '{0, 5, HILT}, '{1, 4, CLAMP_BLADE}};

    RESET = 1'b1; FRAME_START = 1'b0; PIX_IN_VALID = 1'b1;
    DRAW_X = 10'd0; DRAW_Y = 10'd5;
    for (int w = 0; w < 64; w++) reg_data[w*32 +: 32] = $urandom;

    // Reset held with valid pixels driven
    repeat (3) begin
      @(posedge CLK); #1;
      check("reset outputs", {8'b0, PIX_VALID, BLADE_HIT, HILT_HIT, RED, GREEN, BLUE}, 32'd0);
      check("reset blade_len", {22'b0, BLADE_LEN}, 32'd0);
    end
    RESET = 1'b0; PIX_IN_VALID = 1'b0;
    model_reset();
    send_pix(0, 5, HILT);
    drain();

    // Extend
    set_regs(100, 300, 1, 20, 24'h00FF00);
    for (int i = 0; i < 3; i++) begin
      frame();
      check("extend blade_len", {22'b0, BLADE_LEN}, 32'(ext_len[i]));
    end
    foreach (ext_tab[i]) send_pix(ext_tab[i].x, ext_tab[i].y, ext_tab[i].exp);
    drain();

    // FRAME_START boundary: old shadow, then new shadow with old length, then new length
    set_regs(200, 300, 0, 20, 24'h00FF00);
    @(posedge CLK); #1;
    FRAME_START = 1'b1; PIX_IN_VALID = 1'b1; DRAW_X = 10'd100; DRAW_Y = 10'd310;
    exp_q.push_back('{due: cyc + 2, exp: HILT});
    @(posedge CLK); #1;
    FRAME_START = 1'b0; DRAW_X = 10'd200; DRAW_Y = 10'd280;
    exp_q.push_back('{due: cyc + 2, exp: GREEN_BLADE});
    @(posedge CLK); #1;
    exp_q.push_back('{due: cyc + 2, exp: NONE});
    model_frame();
    drain();
    check("retract blade_len", {22'b0, BLADE_LEN}, 32'd12);
    for (int i = 0; i < 2; i++) begin
      frame();
      check("retract blade_len", {22'b0, BLADE_LEN}, 32'(ret_len[i]));
    end

    // Clamp at the top of the screen with maximum length
    set_regs(1, 5, 1, 400, 24'h3366CC);
    repeat (60) frame();
    check("clamp blade_len", {22'b0, BLADE_LEN}, 32'd400);
    foreach (clamp_tab[i]) send_pix(clamp_tab[i].x, clamp_tab[i].y, clamp_tab[i].exp);
    drain();

    // Flicker: 4 frames shown, 4 hidden, repeating; hilt always drawn
    set_regs(1, 5, 2, 8, 24'h3366CC);
    for (int f = 1; f <= 12; f++) begin
      frame();
      check("flicker blade_len", {22'b0, BLADE_LEN}, 32'd8);
      send_pix(1, 4, (f <= 4 || f >= 9) ? CLAMP_BLADE : NONE);
      send_pix(1, 5, HILT);
      drain();
    end

    // Register changes without FRAME_START must not move the saber
    set_regs(300, 200, 1, 30, 24'hC01020);
    repeat (4) frame();
    set_regs(600, 200, 1, 30, 24'hC01020);
    for (int k = 0; k < 2; k++) begin
      send_model(300, 190); send_model(600, 190);
      send_model(300, 205); send_model(600, 205);
      send_model(302, 170); send_model(598, 215);
      drain();
      if (k == 0) frame();
    end

    // Throughput: 640 back-to-back pixels
    for (int i = 0; i < 640; i++)
      send_model(596 + int'($urandom_range(0, 8)), 150 + int'($urandom_range(0, 80)));
    drain();

    // Randomized frames and pixels against the model
    for (int r = 0; r < 30; r++) begin
      int x, y;
      for (int w = 0; w < 64; w++) reg_data[w*32 +: 32] = $urandom;
      set_regs(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)), 24'($urandom));
      repeat ($urandom_range(1, 3)) frame();
      check("random blade_len", {22'b0, BLADE_LEN}, 32'(m_len));
      for (int p = 0; p < 24; p++) begin
        if ($urandom_range(0, 4) == 0) send_idle();
        else begin
          x = m_x - 4 + int'($urandom_range(0, 8));
          y = m_y - m_len - 4 + int'($urandom_range(0, m_len + HILT_LEN + 8));
          if (x < 0) x = 0;
          if (x > 1023) x = 1023;
          if (y < 0) y = 0;
          if (y > 1023) y = 1023;
          send_model(x, y);
        end
      end
      drain();
    end

    // Reset with a pixel in flight
    set_regs(50, 100, 1, 16, 24'h0000FF);
    repeat (2) frame();
    @(posedge CLK); #1;
    PIX_IN_VALID = 1'b1; DRAW_X = 10'd50; DRAW_Y = 10'd100;
    @(posedge CLK); #1;
    RESET = 1'b1; PIX_IN_VALID = 1'b0;
    @(posedge CLK); #1;
    check("midframe reset outputs", {8'b0, PIX_VALID, BLADE_HIT, HILT_HIT, RED, GREEN, BLUE}, 32'd0);
    check("midframe reset blade_len", {22'b0, BLADE_LEN}, 32'd0);
    RESET = 1'b0;
    model_reset();
    send_model(1, 3);
    send_model(50, 100);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
